// File: rtl/clock_div_multi.sv
// clock_div_multi: per-channel tick strobe and 50% square output with glitch-free runtime divisors
module clock_div_multi #(
    parameter int CHANNELS = 2,
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      sync,
    input  logic [CHANNELS*WIDTH-1:0] div,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       out
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : ch
            logic [WIDTH-1:0] cnt;
            logic [WIDTH-1:0] div_act;
            logic [WIDTH-1:0] div_new;
            logic             wrap;
            assign div_new = div[i*WIDTH +: WIDTH];
            assign wrap    = cnt == div_act - ONE;
            // sync restarts, !en freezes, idle loads the shadow divisor, otherwise count and reload at wrap
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt     <= '0;
                    div_act <= '0;
                    tick[i] <= 1'b0;
                    out[i]  <= 1'b0;
                end else if (sync || (en && div_act == '0)) begin
                    cnt     <= '0;
                    div_act <= div_new;
                    tick[i] <= 1'b0;
                    out[i]  <= 1'b0;
                end else if (!en) begin
                    tick[i] <= 1'b0;
                end else if (wrap) begin
                    cnt     <= '0;
                    div_act <= div_new;
                    tick[i] <= 1'b1;
                    out[i]  <= (div_new != '0) ? ~out[i] : 1'b0;
                end else begin
                    cnt     <= cnt + ONE;
                    tick[i] <= 1'b0;
                end
            end
        end
    endgenerate
endmodule

// File: doc/clock_div_multi.md
Name: clock_div_multi

Overview:
- Parametrised multi-channel clock divider. Generates, per channel, a one-cycle `tick` enable strobe and a 50%-duty square output `out` from the single system clock.
- Used for pixel-clock enables, blink or refresh rates and scan timing in the VGA tools.
- Adds over the single-channel divider:
  - runtime divisors latched at period boundaries, so changes cause no glitches;
  - a global enable;
  - a phase-align restart;
  - defined handling of divisors 0 and 1;
  - asynchronous reset.

Parameters:
- CHANNELS, 2, number of independent divider channels (1..16).
- WIDTH, 32, width of each divisor and each internal counter.

Ports:
- clk  input  1  system clock; all state is updated on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global count enable; when low, all channels freeze.
- sync  input  1  restart all channels in phase; takes priority over en.
- div  input  CHANNELS*WIDTH  packed divisors; channel i occupies bits [i*WIDTH +: WIDTH].
- tick  output  CHANNELS  one-cycle strobe, one per channel, once every div_act cycles.
- out  output  CHANNELS  square wave per channel; toggles on each tick, so its period is 2*div_act cycles.

Behaviour:
- Per-channel registers: cnt[WIDTH], div_act[WIDTH] (the divisor currently in use), tick, out. All outputs are registered.
- Reset (rst high, asynchronous): cnt=0, div_act=0, tick=0, out=0 for every channel. Reset may assert mid-period; all state clears immediately.
- Priority on each rising clk edge, evaluated per channel: sync, then !en, then idle, then count.
- sync=1 (regardless of en): cnt<=0, tick<=0, out<=0, div_act<=div[i]. All channels are then phase-aligned.
- en=0, sync=0: cnt, div_act and out hold; tick<=0.
- Idle state (div_act==0), en=1: cnt<=0, tick<=0, out<=0, div_act<=div[i]. An idle channel therefore picks up a new nonzero divisor on the next enabled edge.
- Counting state (div_act>=1), en=1:
  - If cnt==div_act-1 (wrap): cnt<=0, tick<=1, div_act<=div[i] (shadow reload).
    - out<=~out if the new div[i]!=0.
    - out<=0 if the new div[i]==0; the channel then goes idle.
  - Otherwise: cnt<=cnt+1, tick<=0, out holds.
- Timing: if div_act=D is loaded at edge E0 (by sync or an idle load), tick is high in the cycles following edges E0+D, E0+2D, and so on. Each tick lasts exactly one cycle.
- div=1: tick is high every enabled cycle; out toggles every cycle (clk/2).
- div=D: out is high for D cycles and low for D cycles, giving exact 50% duty for every D.
- Divisor changes mid-period do not affect the current period. They take effect at the next wrap, or immediately on sync or when the channel is idle.
- Channels are fully independent except for the shared en, sync and rst.
- Arithmetic: cnt compares against div_act-1 only when div_act>=1, so there is no underflow. The maximum divisor 2^WIDTH-1 is legal.

Test Plan:
- Reset, then CHANNELS=2, div={32'd3, 32'd4}, en=1, one-cycle sync pulse:
  - ch0 tick every 4 cycles, out period 8;
  - ch1 tick every 3 cycles, out period 6;
  - first ch0 tick on the 4th edge after the sync edge.
- div0=1:
  - tick0 held high continuously;
  - out0 alternates 0,1,0,1.
- div0=5, change to 2 at cycle 2 of a period:
  - current period still completes at 5 cycles;
  - subsequent ticks every 2 cycles;
  - no short or extra pulse on out0.
- div0=0 from reset:
  - tick0=0 and out0=0 indefinitely.
- Then set div0=3:
  - first tick on the 3rd edge after the load edge.
- Later set div0=0 at the next wrap:
  - out0 forced to 0;
  - channel idles.
- en low for 7 cycles mid-period with div=4:
  - tick stays 0, cnt and out freeze;
  - after en returns high, the period resumes from the frozen cnt.
- sync asserted while en=0:
  - channels still restart;
  - both outs are 0.
- rst asserted mid-count between clock edges:
  - outputs clear before the next edge.
- After rst release with div={4,4} and sync:
  - ticks on both channels are coincident.
